// File: rtl/tiny_alu_pkg.sv
// Shared types and defaults for the tiny_alu responder core.
package tiny_alu_pkg;

    localparam int DEF_INPUT_DATA_BITS = 8;
    localparam int DEF_OPCODE_BITS     = 3;
    localparam int DEF_MUL_LATENCY     = 3;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE,
        ST_RELEASE
    } state_e;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op >= 8'd1) && (op <= 8'd4);
    endfunction

endpackage

// File: rtl/tiny_alu_mul_pipe.sv
// Fixed-latency unsigned multiplier: product enters at the capture edge and
// emerges with valid_o after LATENCY register stages.
module tiny_alu_mul_pipe #(
    parameter int W       = 8,
    parameter int LATENCY = 3
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           valid_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           valid_o,
    output logic [2*W-1:0] prod_o
);

    localparam int PW = 2 * W;

    logic [PW-1:0]      prod_q [LATENCY];
    logic [LATENCY-1:0] vld_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) prod_q[i] <= '0;
        end else begin
            vld_q     <= {vld_q[LATENCY-2:0], valid_i};
            prod_q[0] <= PW'(a_i) * PW'(b_i);
            for (int i = 1; i < LATENCY; i++) prod_q[i] <= prod_q[i-1];
        end
    end

    assign valid_o = vld_q[LATENCY-1];
    assign prod_o  = prod_q[LATENCY-1];

endmodule

// File: rtl/tiny_alu_core.sv
// tiny_alu responder: latches an operation on start_i, executes it and
// returns a one-cycle done_o pulse with a double-width result_o.
module tiny_alu_core
    import tiny_alu_pkg::*;
#(
    parameter int INPUT_DATA_BITS = DEF_INPUT_DATA_BITS,
    parameter int OPCODE_BITS     = DEF_OPCODE_BITS,
    parameter int MUL_LATENCY     = DEF_MUL_LATENCY
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         start_i,
    input  logic [OPCODE_BITS-1:0]       op_i,
    input  logic [INPUT_DATA_BITS-1:0]   a_i,
    input  logic [INPUT_DATA_BITS-1:0]   b_i,
    output logic                         done_o,
    output logic [2*INPUT_DATA_BITS-1:0] result_o
);

    localparam int W  = INPUT_DATA_BITS;
    localparam int OB = OPCODE_BITS;
    localparam int RW = 2 * INPUT_DATA_BITS;

    state_e         state_q;
    logic [W-1:0]   a_q, b_q;
    logic [OB-1:0]  op_q;
    logic           done_q;
    logic [RW-1:0]  result_q;
    logic           capture, mul_start, mul_valid;
    logic [RW-1:0]  mul_prod, alu_res;

    // Handshake: start_i is a level request held until done_o is seen; it is
    // accepted only in IDLE, and a held start must drop before the next accept.
    assign capture   = (state_q == ST_IDLE) && start_i && (op_i != '0);
    assign mul_start = capture && (op_i == OB'(OP_MUL));

    tiny_alu_mul_pipe #(
        .W       (W),
        .LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (mul_start),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (mul_valid),
        .prod_o  (mul_prod)
    );

    always_comb begin
        alu_res = '0;
        if (is_legal_op(8'(op_q))) begin
            if (op_q == OB'(OP_ADD))      alu_res = RW'(a_q) + RW'(b_q);
            else if (op_q == OB'(OP_AND)) alu_res = RW'(a_q & b_q);
            else if (op_q == OB'(OP_XOR)) alu_res = RW'(a_q ^ b_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        op_q    <= op_i;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (op_q == OB'(OP_MUL)) begin
                        if (mul_valid) begin
                            result_q <= mul_prod;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end else begin
                        result_q <= alu_res;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= start_i ? ST_RELEASE : ST_IDLE;
                end
                ST_RELEASE: begin
                    if (!start_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_tiny_alu_core.sv
// Bench for tiny_alu_core: transaction-level model with an expected-result
// queue, a per-cycle compare process, and directed literal checks.
module tb_tiny_alu_core;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        done;
    logic [15:0] result;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    tiny_alu_core #(
        .INPUT_DATA_BITS (8),
        .OPCODE_BITS     (3),
        .MUL_LATENCY     (MUL_LAT)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .done_o   (done),
        .result_o (result)
    );

    function automatic logic [15:0] ref_calc(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int unsigned ux = x;
        int unsigned uy = y;
        case (o)
            3'd1: return 16'(ux + uy);
            3'd2: return 16'(ux & uy);
            3'd3: return 16'(ux ^ uy);
            3'd4: return 16'(ux * uy);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: accepted ops queue their result; a countdown marks when it is due,
    // and a held start after completion must be seen low before a new accept.
    logic [15:0] exp_q[$];
    bit          m_done;
    logic [15:0] m_result;
    int          m_left;
    bit          m_gate;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_done   = 1'b0;
            m_result = '0;
            m_left   = 0;
            m_gate   = 1'b0;
            exp_q.delete();
        end else if (m_done) begin
            m_done = 1'b0;
            m_gate = start;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done   = 1'b1;
                m_result = exp_q.pop_front();
            end
        end else if (m_gate) begin
            if (!start) m_gate = 1'b0;
        end else if (start && op != 3'd0) begin
            exp_q.push_back(ref_calc(op, a, b));
            m_left = (op == 3'd4) ? MUL_LAT : 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cycle done_o", 32'(done), 32'(m_done));
            chk("cycle result_o", 32'(result), 32'(m_result));
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input int hold, input bit churn, input string nm,
                         input logic [15:0] exp_res, input int exp_lat);
        int cnt = 0;
        bit seen = 1'b0;
        start = 1'b1; op = o; a = x; b = y;
        while (!seen && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (done) seen = 1'b1;
            else if (churn) begin
                a = 8'($urandom);
                b = 8'($urandom);
                op = 3'($urandom);
                if ($urandom_range(0, 1) == 1) start = 1'b0;
            end
        end
        chk({nm, " done seen"}, 32'(seen), 32'd1);
        chk({nm, " latency"}, 32'(cnt), 32'(exp_lat + 1));
        chk({nm, " result"}, 32'(result), 32'(exp_res));
        repeat (hold) begin
            @(negedge clk);
            chk({nm, " no retrigger"}, 32'(done), 32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        chk({nm, " done one cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ro;
        logic [7:0] ra, rb;
        int         nop_dones;

        repeat (3) @(negedge clk);
        chk("reset done_o", 32'(done), 32'd0);
        chk("reset result_o", 32'(result), 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        do_op(3'd1, 8'hFF, 8'h01, 0, 1'b0, "add carry", 16'h0100, 1);
        do_op(3'd2, 8'hF0, 8'h3C, 0, 1'b0, "and", 16'h0030, 1);
        do_op(3'd3, 8'hF0, 8'h3C, 0, 1'b0, "xor", 16'h00CC, 1);
        do_op(3'd4, 8'hFF, 8'hFF, 0, 1'b0, "mul max", 16'hFE01, MUL_LAT);
        do_op(3'd4, 8'h0C, 8'h0B, 5, 1'b0, "mul held start", 16'h0084, MUL_LAT);
        do_op(3'd1, 8'h02, 8'h03, 0, 1'b0, "add after release", 16'h0005, 1);

        // Async reset during the second cycle of a MUL.
        start = 1'b1; op = 3'd4; a = 8'h10; b = 8'h10;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midop reset done_o", 32'(done), 32'd0);
        chk("midop reset result_o", 32'(result), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post reset no done", 32'(done), 32'd0);
        end

        do_op(3'd1, 8'h03, 8'h04, 0, 1'b0, "add pre nop", 16'h0007, 1);
        start = 1'b1; op = 3'd0; a = 8'h12; b = 8'h34;
        nop_dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) nop_dones++;
        end
        chk("nop never done", 32'(nop_dones), 32'd0);
        start = 1'b0;
        @(negedge clk);
        do_op(3'd5, 8'hAA, 8'h55, 0, 1'b0, "illegal op", 16'h0000, 1);
        do_op(3'd4, 8'h07, 8'h09, 0, 1'b1, "mul churn", 16'h003F, MUL_LAT);

        for (int i = 0; i < 120; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (ro == 3'd0) begin
                start = 1'b1; op = ro; a = ra; b = rb;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                start = 1'b0;
                @(negedge clk);
            end else begin
                do_op(ro, ra, rb, $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                      "random", ref_calc(ro, ra, rb), (ro == 3'd4) ? MUL_LAT : 1);
            end
        end

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
